// File: rtl/fsk_frame_decoder.sv
// Serial FSK frame decoder: header hunt, DATA_W-bit payload deserialise, single parity check.
// Define FSK_DEC_STATS_EN to add saturating frame/error counters (frame_cnt, err_cnt).
module fsk_frame_decoder #(
  parameter int                 HDR_LEN     = 3,
  parameter logic [HDR_LEN-1:0] HDR_PATTERN = 3'b111,
  parameter int                 DATA_W      = 4,
  parameter int                 PARITY_ODD  = 0
`ifdef FSK_DEC_STATS_EN
  ,
  parameter int                 CNT_W       = 8
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_en,
  input  logic              IN,
  output logic [DATA_W-1:0] OUT,
  output logic              WRONG,
  output logic              out_valid,
  output logic              locked
`ifdef FSK_DEC_STATS_EN
  ,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_cnt
`endif
);

  localparam int IW = $clog2(DATA_W + 1);
  localparam int FW = $clog2(HDR_LEN + 1);

  typedef enum logic [1:0] {HUNT, DATA, PARITY} state_t;

  state_t              state_q, state_d;
  logic [HDR_LEN-1:0]  win_q, win_d, win_sh;
  logic [FW-1:0]       fill_q, fill_d, fill_sh;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DATA_W-1:0]   pay_q, pay_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                wrong_q, wrong_d;
  logic                vld_q, vld_d;
  logic                par;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HUNT;
      win_q   <= '0;
      fill_q  <= '0;
      idx_q   <= '0;
      pay_q   <= '0;
      out_q   <= '0;
      wrong_q <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      fill_q  <= fill_d;
      idx_q   <= idx_d;
      pay_q   <= pay_d;
      out_q   <= out_d;
      wrong_q <= wrong_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    fill_d  = fill_q;
    idx_d   = idx_q;
    pay_d   = pay_q;
    out_d   = out_q;
    wrong_d = wrong_q;
    vld_d   = 1'b0;
    // Candidate window/fill for the hunt; the fill count gates matches on stale bits.
    win_sh    = win_q << 1;
    win_sh[0] = IN;
    fill_sh   = (fill_q == FW'(HDR_LEN)) ? fill_q : fill_q + FW'(1);
    par       = (^pay_q) ^ IN;
    if (in_en) begin
      case (state_q)
        HUNT: begin
          win_d  = win_sh;
          fill_d = fill_sh;
          if ((fill_sh == FW'(HDR_LEN)) && (win_sh == HDR_PATTERN)) begin
            state_d = DATA;
            idx_d   = '0;
          end
        end
        DATA: begin
          for (int i = 0; i < DATA_W; i++) begin
            if (idx_q == IW'(i)) pay_d[i] = IN;
          end
          idx_d = idx_q + IW'(1);
          if (idx_q == IW'(DATA_W - 1)) state_d = PARITY;
        end
        PARITY: begin
          out_d   = pay_q;
          wrong_d = (PARITY_ODD != 0) ? ~par : par;
          vld_d   = 1'b1;
          state_d = HUNT;
          fill_d  = '0;
          win_d   = '0;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign OUT       = out_q;
  assign WRONG     = wrong_q;
  assign out_valid = vld_q;
  assign locked    = (state_q == DATA) || (state_q == PARITY);

`ifdef FSK_DEC_STATS_EN
  logic [CNT_W-1:0] fcnt_q, ecnt_q;

  // Counters advance on the same edge that publishes the frame, saturating at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fcnt_q <= '0;
      ecnt_q <= '0;
    end else if (vld_d) begin
      if (!(&fcnt_q)) fcnt_q <= fcnt_q + CNT_W'(1);
      if (wrong_d && !(&ecnt_q)) ecnt_q <= ecnt_q + CNT_W'(1);
    end
  end

  assign frame_cnt = fcnt_q;
  assign err_cnt   = ecnt_q;
`endif

endmodule

// File: tb/tb_fsk_frame_decoder.sv
// Bench for fsk_frame_decoder: fixed frame table, corner sequences, random stream vs. queue-based model.
module tb_fsk_frame_decoder;
  localparam int HLEN = 3;
  localparam int DW = 4;
  localparam logic [HLEN-1:0] PAT = 3'b111;

  logic clk = 1'b0;
  logic reset, in_en, IN;
  logic [DW-1:0] out0, out1;
  logic w0, w1, v0, v1, l0, l1;
`ifdef FSK_DEC_STATS_EN
  logic [1:0] fc0, ec0, fc1, ec1;
`endif

  always #5 clk = ~clk;

  fsk_frame_decoder #(.HDR_LEN(HLEN), .HDR_PATTERN(PAT), .DATA_W(DW), .PARITY_ODD(0)
`ifdef FSK_DEC_STATS_EN
    , .CNT_W(2)
`endif
  ) dut0 (
    .clk(clk), .reset(reset), .in_en(in_en), .IN(IN),
    .OUT(out0), .WRONG(w0), .out_valid(v0), .locked(l0)
`ifdef FSK_DEC_STATS_EN
    , .frame_cnt(fc0), .err_cnt(ec0)
`endif
  );

  fsk_frame_decoder #(.HDR_LEN(HLEN), .HDR_PATTERN(PAT), .DATA_W(DW), .PARITY_ODD(1)
`ifdef FSK_DEC_STATS_EN
    , .CNT_W(2)
`endif
  ) dut1 (
    .clk(clk), .reset(reset), .in_en(in_en), .IN(IN),
    .OUT(out1), .WRONG(w1), .out_valid(v1), .locked(l1)
`ifdef FSK_DEC_STATS_EN
    , .frame_cnt(fc1), .err_cnt(ec1)
`endif
  );

  int total = 0;
  int bad = 0;
  int vcount = 0;

  // Reference model: recent bits since hunt entry, bits collected since header match.
  bit hist[$];
  bit frm[$];
  bit m_in_frame;
  logic [DW-1:0] m_out;
  logic m_w0, m_w1, m_valid;
  int m_fc, m_ec0, m_ec1;

  typedef struct {
    logic [7:0]    bits;
    logic [DW-1:0] out;
    logic          we;
    logic          wo;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    frm.delete();
    m_in_frame = 0;
    m_out = '0;
    m_w0 = 0;
    m_w1 = 0;
    m_valid = 0;
    m_fc = 0;
    m_ec0 = 0;
    m_ec1 = 0;
  endtask

  task automatic model_accept(input bit b);
    bit match;
    int ones;
    logic [DW-1:0] w;
    m_valid = 0;
    if (!m_in_frame) begin
      hist.push_back(b);
      if (hist.size() > HLEN) void'(hist.pop_front());
      if (hist.size() == HLEN) begin
        match = 1;
        for (int k = 0; k < HLEN; k++)
          if (hist[k] != PAT[HLEN-1-k]) match = 0;
        if (match) begin
          m_in_frame = 1;
          hist.delete();
          frm.delete();
        end
      end
    end else begin
      frm.push_back(b);
      if (frm.size() == DW + 1) begin
        ones = 0;
        w = '0;
        for (int i = 0; i < DW; i++) begin
          w[i] = frm[i];
          ones += int'(frm[i]);
        end
        ones += int'(frm[DW]);
        m_out = w;
        m_w0 = (ones % 2) != 0;
        m_w1 = (ones % 2) == 0;
        m_valid = 1;
        m_in_frame = 0;
        frm.delete();
        hist.delete();
        if (m_fc < 3) m_fc++;
        if (m_w0 && m_ec0 < 3) m_ec0++;
        if (m_w1 && m_ec1 < 3) m_ec1++;
      end
    end
  endtask

  task automatic check_all();
    chk("out0", 32'(out0), 32'(m_out));
    chk("out1", 32'(out1), 32'(m_out));
    chk("wrong0", 32'(w0), 32'(m_w0));
    chk("wrong1", 32'(w1), 32'(m_w1));
    chk("valid0", 32'(v0), 32'(m_valid));
    chk("valid1", 32'(v1), 32'(m_valid));
    chk("locked0", 32'(l0), 32'(m_in_frame));
    chk("locked1", 32'(l1), 32'(m_in_frame));
`ifdef FSK_DEC_STATS_EN
    chk("fcnt0", 32'(fc0), 32'(m_fc));
    chk("ecnt0", 32'(ec0), 32'(m_ec0));
    chk("fcnt1", 32'(fc1), 32'(m_fc));
    chk("ecnt1", 32'(ec1), 32'(m_ec1));
`endif
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic en, input logic b);
    in_en = en;
    IN = b;
    @(posedge clk);
    if (en) model_accept(b);
    else m_valid = 0;
    @(negedge clk);
    check_all();
    if (v0) vcount++;
  endtask

  task automatic send_frame(input logic [7:0] bits, input int hold);
    for (int i = 7; i >= 0; i--)
      for (int r = 0; r < hold; r++) step(r == 0, bits[i]);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    tbl[0] = '{8'b11111011, 4'b1011, 1'b0, 1'b1};
    tbl[1] = '{8'b11111010, 4'b1011, 1'b1, 1'b0};
    tbl[2] = '{8'b11100000, 4'b0000, 1'b0, 1'b1};
    tbl[3] = '{8'b11110000, 4'b0001, 1'b1, 1'b0};
    tbl[4] = '{8'b11101100, 4'b0110, 1'b0, 1'b1};

    reset = 1'b0;
    in_en = 1'b0;
    IN = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_out", 32'(out0), 32'h0);
    chk("rst_wrong", 32'(w0), 32'h0);
    chk("rst_valid", 32'(v0), 32'h0);
    chk("rst_locked", 32'(l0), 32'h0);
    check_all();
    reset = 1'b1;

    // Back-to-back fixed frames, both parity senses.
    for (int i = 0; i < 5; i++) begin
      send_frame(tbl[i].bits, 1);
      chk("tbl_out", 32'(out0), 32'(tbl[i].out));
      chk("tbl_wrong_even", 32'(w0), 32'(tbl[i].we));
      chk("tbl_wrong_odd", 32'(w1), 32'(tbl[i].wo));
      chk("tbl_valid", 32'(v0), 32'h1);
      chk("tbl_locked", 32'(l0), 32'h0);
    end

    // Sparse bit strobe: one valid pulse for a stretched frame.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    vcount = 0;
    send_frame(8'b11111011, 4);
    step(1'b0, 1'b0);
    chk("sparse_vcount", 32'(vcount), 32'h1);
    chk("sparse_out", 32'(out0), 32'hB);
    chk("sparse_wrong", 32'(w0), 32'h0);

    // Header after false starts: locked only on the final 1.
    do_reset();
    step(1'b1, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b1);
    step(1'b1, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b1);
    chk("hunt_not_locked", 32'(l0), 32'h0);
    step(1'b1, 1'b1);
    chk("hunt_locked", 32'(l0), 32'h1);
    step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("hunt_out", 32'(out0), 32'hB);
    chk("hunt_wrong", 32'(w0), 32'h0);
    chk("hunt_unlocked", 32'(l0), 32'h0);

    // Reset in the middle of a payload.
    send_frame(8'b11111011, 1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    chk("mid_locked", 32'(l0), 32'h1);
    reset = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_out", 32'(out0), 32'h0);
    chk("mid_rst_locked", 32'(l0), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    send_frame(8'b11111011, 1);
    chk("post_rst_out", 32'(out0), 32'hB);
    chk("post_rst_wrong", 32'(w0), 32'h0);

`ifdef FSK_DEC_STATS_EN
    do_reset();
    send_frame(8'b11111011, 1);
    send_frame(8'b11111011, 1);
    send_frame(8'b11111011, 1);
    send_frame(8'b11111010, 1);
    chk("stat_frames", 32'(fc0), 32'h3);
    chk("stat_errs", 32'(ec0), 32'h1);
    send_frame(8'b11111011, 1);
    chk("stat_frames_sat", 32'(fc0), 32'h3);
    chk("stat_errs_hold", 32'(ec0), 32'h1);
`endif

    // Random stream with occasional resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
